// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm FSM gating policeSiren.enb, with stop, limited snooze and ring auto-timeout.
module alarm_sequencer #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic [4:0] alm_hour,
    input  logic [5:0] alm_min,
    input  logic       alarm_arm,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic       siren_enb,
    output logic       snoozing,
    output logic [3:0] snooze_left,
    output logic       missed_pulse
);
    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

    localparam logic [15:0] RING_LAST = 16'(RING_TIMEOUT_S - 1);
    localparam logic [15:0] SNZ_LAST  = 16'(SNOOZE_S - 1);
    localparam logic [3:0]  SNZ_MAX   = 4'(MAX_SNOOZE);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        missed_d;
    logic        match;

    assign match = tick_1hz && cur_hour == alm_hour && cur_min == alm_min && cur_sec == 6'd0;
    assign snooze_left = SNZ_MAX - cnt_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        missed_d = 1'b0;
        if (!alarm_arm) begin
            state_d = IDLE;
            timer_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: if (match) begin
                    state_d = RINGING;
                    timer_d = '0;
                    cnt_d   = '0;
                end
                RINGING: begin
                    if (stop_btn) begin
                        state_d = ARMED;
                        timer_d = '0;
                    end else if (snooze_btn && cnt_q < SNZ_MAX) begin
                        state_d = SNOOZE;
                        timer_d = '0;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (tick_1hz) begin
                        // expiry is checked before increment so the timer never wraps
                        state_d  = timer_q == RING_LAST ? ARMED : RINGING;
                        missed_d = timer_q == RING_LAST;
                        timer_d  = timer_q == RING_LAST ? 16'd0 : timer_q + 16'd1;
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_d = ARMED;
                        timer_d = '0;
                    end else if (tick_1hz) begin
                        state_d = timer_q == SNZ_LAST ? RINGING : SNOOZE;
                        timer_d = timer_q == SNZ_LAST ? 16'd0 : timer_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cnt_q        <= '0;
            siren_enb    <= 1'b0;
            snoozing     <= 1'b0;
            missed_pulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            siren_enb    <= state_d == RINGING;
            snoozing     <= state_d == SNOOZE;
            missed_pulse <= missed_d;
        end
    end
endmodule
